// File: rtl/key_event_pkg.sv
// key_event_pkg: shared types for the key event classifier.
// Holds the FSM state enum, the default counter width and a width helper.
package key_event_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT2,
        HELD,
        WAIT_REL
    } state_e;

    // Counter width for the default timing: $clog2(10_000_000) + 1.
    localparam int CNT_W_DEF = 25;

    // Width of the shared counter: enough to hold the largest period.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/key_event_classifier_edge.sv
// key_edge: registers the debounced key and flags its rising/falling edges.
// Ports: clk, rstn (sync, active-low), key_i in; rise_o, fall_o out.
module key_edge (
    input  logic clk,
    input  logic rstn,
    input  logic key_i,
    output logic rise_o,
    output logic fall_o
);

    logic key_q;

    always_ff @(posedge clk) begin
        if (!rstn) key_q <= 1'b0;
        else       key_q <= key_i;
    end

    // key_q clears in reset, so a key held through reset yields a fresh rise.
    assign rise_o = key_i & ~key_q;
    assign fall_o = ~key_i & key_q;

endmodule

// File: rtl/key_event_classifier.sv
// key_event_classifier: turns a debounced key level into short, double and
// long press pulses, plus optional auto-repeat pulses while a long press is
// held (compiled in when KEY_REPEAT_EN is defined).
// Ports: clk, rstn (sync, active-low), button_in in; short_pulse,
// double_pulse, long_pulse, repeat_pulse (one-cycle pulses) and busy out.
module key_event_classifier
    import key_event_pkg::*;
#(
    parameter logic [23:0] LONG_CNT    = 24'd10_000_000,
    parameter logic [23:0] DBL_GAP_CNT = 24'd5_000_000,
    parameter logic [23:0] REPEAT_CNT  = 24'd2_500_000
) (
    input  logic clk,
    input  logic rstn,
    input  logic button_in,
    output logic short_pulse,
    output logic double_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic busy
);

    localparam int CW = cnt_width(int'(LONG_CNT), int'(DBL_GAP_CNT),
                                  int'(REPEAT_CNT));

    localparam logic [CW-1:0] ONE    = CW'(1);
    localparam logic [CW-1:0] L_TERM = CW'(LONG_CNT - 24'd1);
    localparam logic [CW-1:0] D_TERM = CW'(DBL_GAP_CNT - 24'd1);

    logic rise, fall;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          short_q, short_d;
    logic          dbl_q, dbl_d;
    logic          long_q, long_d;

    key_edge u_edge (
        .clk    (clk),
        .rstn   (rstn),
        .key_i  (button_in),
        .rise_o (rise),
        .fall_o (fall)
    );

`ifdef KEY_REPEAT_EN
    localparam logic [CW-1:0] R_TERM = CW'(REPEAT_CNT);
    logic rep_q, rep_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        short_d = 1'b0;
        dbl_d   = 1'b0;
        long_d  = 1'b0;
`ifdef KEY_REPEAT_EN
        rep_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = PRESS1;
                    cnt_d   = ONE;
                end
            end
            // Release is checked first so a fall on the terminal sample
            // still counts as a short press.
            PRESS1: begin
                if (fall) begin
                    state_d = WAIT2;
                    cnt_d   = ONE;
                end else if (cnt_q == L_TERM) begin
                    state_d = HELD;
                    cnt_d   = ONE;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            // A rise on the terminal sample wins: the gesture is a double.
            WAIT2: begin
                if (rise) begin
                    state_d = WAIT_REL;
                    cnt_d   = '0;
                    dbl_d   = 1'b1;
                end else if (cnt_q == D_TERM) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    short_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            HELD: begin
                if (fall) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
`ifdef KEY_REPEAT_EN
                else if (cnt_q == R_TERM) begin
                    cnt_d = ONE;
                    rep_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
`endif
            end
            WAIT_REL: begin
                if (fall) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            short_q <= 1'b0;
            dbl_q   <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            short_q <= short_d;
            dbl_q   <= dbl_d;
            long_q  <= long_d;
        end
    end

`ifdef KEY_REPEAT_EN
    always_ff @(posedge clk) begin
        if (!rstn) rep_q <= 1'b0;
        else       rep_q <= rep_d;
    end
    assign repeat_pulse = rep_q;
`else
    assign repeat_pulse = 1'b0;
`endif

    assign short_pulse  = short_q;
    assign double_pulse = dbl_q;
    assign long_pulse   = long_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_key_event_classifier.sv
// Testbench for key_event_classifier with LONG=16, DBL_GAP=8, REPEAT=4.
// Gesture table plus reset sequences, checked through an event scoreboard.
module tb_key_event_classifier;

    localparam int LONG = 16;
    localparam int GAP  = 8;
    localparam int REP  = 4;

    localparam int K_NONE   = 0;
    localparam int K_SHORT  = 1;
    localparam int K_DOUBLE = 2;
    localparam int K_LONG   = 3;
    localparam int K_REP    = 4;

    logic clk = 1'b0;
    logic rstn;
    logic button_in;
    logic short_pulse, double_pulse, long_pulse, repeat_pulse, busy;

    key_event_classifier #(
        .LONG_CNT    (24'd16),
        .DBL_GAP_CNT (24'd8),
        .REPEAT_CNT  (24'd4)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .button_in    (button_in),
        .short_pulse  (short_pulse),
        .double_pulse (double_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct {
        int kind;
        int at;
    } ev_t;

    ev_t expq[$];
    ev_t gotq[$];

    // Every pulse seen is logged with the index of the edge that made it.
    always @(negedge clk) begin
        if (short_pulse)  gotq.push_back('{K_SHORT, edge_n});
        if (double_pulse) gotq.push_back('{K_DOUBLE, edge_n});
        if (long_pulse)   gotq.push_back('{K_LONG, edge_n});
        if (repeat_pulse) gotq.push_back('{K_REP, edge_n});
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", nm, got, want);
        end
    endtask

    task automatic step(input logic lvl);
        button_in = lvl;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic lvl, input int n);
        for (int i = 0; i < n; i++) step(lvl);
    endtask

    task automatic push_ev(input int kind, input int at);
        expq.push_back('{kind, at});
    endtask

    // Long press expected at edge `at`; repeats follow while still held.
    task automatic push_long(input int at, input int last_high);
        push_ev(K_LONG, at);
`ifdef KEY_REPEAT_EN
        for (int t = at + REP; t <= last_high; t += REP) push_ev(K_REP, t);
`else
        if (last_high < 0) push_ev(K_NONE, 0);
`endif
    endtask

    task automatic score(input string nm);
        ev_t e, g;
        chk({nm, " event count"}, gotq.size(), expq.size());
        while (expq.size() > 0) begin
            e = expq.pop_front();
            if (gotq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL %s: no event, required kind %0d at edge %0d",
                         nm, e.kind, e.at);
            end else begin
                g = gotq.pop_front();
                chk({nm, " kind"}, g.kind, e.kind);
                chk({nm, " edge"}, g.at, e.at);
            end
        end
        while (gotq.size() > 0) begin
            g = gotq.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL %s: extra event kind %0d at edge %0d, required none",
                     nm, g.kind, g.at);
        end
    endtask

    typedef struct {
        string name;
        int    h1, l1, h2, l2;
        int    k1, o1;
        int    k2, o2;
    } vec_t;

    vec_t vt[9];
    int   base;

    initial begin
        // offsets are edges after the first high sample of the gesture
        vt[0] = '{"short",      5, 10, 0,  0, K_SHORT,  12, K_NONE,   0};
        vt[1] = '{"double",     3,  4, 3, 10, K_DOUBLE,  7, K_NONE,   0};
        vt[2] = '{"long30",    30, 10, 0,  0, K_LONG,   15, K_NONE,   0};
        vt[3] = '{"gap7",       3,  7, 2, 10, K_DOUBLE, 10, K_NONE,   0};
        vt[4] = '{"gap8",       3,  8, 5, 10, K_SHORT,  10, K_SHORT, 23};
        vt[5] = '{"fall_at16", 15, 10, 0,  0, K_SHORT,  22, K_NONE,   0};
        vt[6] = '{"long16",    16, 10, 0,  0, K_LONG,   15, K_NONE,   0};
        vt[7] = '{"long_then", 20,  3, 3, 10, K_LONG,   15, K_SHORT, 33};
        vt[8] = '{"dbl_hold",   2,  2, 25, 10, K_DOUBLE, 4, K_NONE,   0};

        rstn      = 1'b0;
        button_in = 1'b0;
        run(1'b0, 3);
        chk("reset busy",   busy,         1'b0);
        chk("reset short",  short_pulse,  1'b0);
        chk("reset double", double_pulse, 1'b0);
        chk("reset long",   long_pulse,   1'b0);
        chk("reset repeat", repeat_pulse, 1'b0);
        rstn = 1'b1;
        run(1'b0, 3);
        score("reset");

        for (int i = 0; i < 9; i++) begin
            step(1'b1);
            base = edge_n;
            chk({vt[i].name, " busy rise"}, busy, 1'b1);
            if (vt[i].k1 == K_LONG)
                push_long(base + vt[i].o1, base + vt[i].h1 - 1);
            else
                push_ev(vt[i].k1, base + vt[i].o1);
            if (vt[i].k2 != K_NONE) push_ev(vt[i].k2, base + vt[i].o2);
            run(1'b1, vt[i].h1 - 1);
            run(1'b0, vt[i].l1);
            run(1'b1, vt[i].h2);
            run(1'b0, vt[i].l2);
            run(1'b0, 2);
            chk({vt[i].name, " busy idle"}, busy, 1'b0);
            score(vt[i].name);
        end

        // Reset while PRESS1 has counted 10 high samples, key kept high.
        run(1'b1, 10);
        chk("midrst busy before", busy, 1'b1);
        rstn = 1'b0;
        step(1'b1);
        chk("midrst busy",   busy,         1'b0);
        chk("midrst short",  short_pulse,  1'b0);
        chk("midrst double", double_pulse, 1'b0);
        chk("midrst long",   long_pulse,   1'b0);
        chk("midrst repeat", repeat_pulse, 1'b0);
        rstn = 1'b1;
        step(1'b1);
        base = edge_n;
        chk("midrst new gesture busy", busy, 1'b1);
        push_long(base + LONG - 1, base + 19);
        run(1'b1, 19);
        run(1'b0, GAP + 2);
        chk("midrst busy idle", busy, 1'b0);
        score("midrst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
